// File: rtl/kp_pkg.sv
// Shared types, key map and row decoder for the 4x4 keypad scanner.
package kp_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] row;
   } key_hit_t;

   // Indexed [row][col]; col 0 is the column driven by cols[0].
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   // A key counts only when exactly one row line is pulled low.
   function automatic key_hit_t onehot0_low(input logic [3:0] rs);
      key_hit_t    hit;
      int unsigned n_low;
      hit   = '0;
      n_low = 0;
      for (int i = 0; i < 4; i++) begin
         if (!rs[i]) begin
            n_low++;
            hit.row = 2'(i);
         end
      end
      hit.valid = (n_low == 1);
      return hit;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         // NOTE: non-blocking keeps this a two-stage pipeline; blocking would collapse it to one flop.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, tick-based debounce, and an
// 8-nibble shift register of accepted keys for the 7-segment driver.
module keypad_scanner
   import kp_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [3:0]  rows,
   output logic [3:0]  cols,
   input  logic        clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [31:0] digits
);

   localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE_SCANS);

   logic [3:0]       rs;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   kp_state_t   state_q;
   logic [1:0]  col_q, row_q;
   logic [3:0]  cnt_q;
   logic [3:0]  key_code_q;
   logic        key_valid_q, key_held_q;
   logic [31:0] digits_q;

   key_hit_t   hit;
   logic [3:0] latched_rs, cnt_inc, new_code;
   logic       rs_idle, accept;
   logic [1:0] accept_row;

   sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_rows_sync (
      .clk_i  (CLK),
      .rst_ni (reset),
      .d_i    (rows),
      .q_o    (rs)
   );

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: assign every output a default first so no branch can infer a latch.
      div_d = div_q + DIV_W'(1);
      if (tick) div_d = '0;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) div_q <= '0;
      else        div_q <= div_d;
   end

   assign hit        = onehot0_low(rs);
   assign latched_rs = ~(4'b0001 << row_q);
   assign rs_idle    = (rs == 4'hF);
   assign cnt_inc    = cnt_q + 4'd1;

   // A press is accepted on the tick that completes the debounce run.
   always_comb begin
      accept     = 1'b0;
      accept_row = row_q;
      if (tick) begin
         if (state_q == SCAN && hit.valid && DB_LAST == 4'd1) begin
            accept     = 1'b1;
            accept_row = hit.row;
         end else if (state_q == DEBOUNCE && rs == latched_rs && cnt_inc == DB_LAST) begin
            accept = 1'b1;
         end
      end
   end

   assign new_code = KEY_MAP[accept_row][col_q];

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= 4'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         digits_q    <= 32'h0;
      end else begin
         key_valid_q <= accept;
         if (accept) begin
            key_code_q <= new_code;
            key_held_q <= 1'b1;
         end
         // Clear beats a same-cycle shift; the key is dropped from the register.
         if (clr)         digits_q <= 32'h0;
         else if (accept) digits_q <= {digits_q[27:0], new_code};

         if (tick) begin
            case (state_q)
               SCAN: begin
                  if (hit.valid) begin
                     row_q   <= hit.row;
                     cnt_q   <= 4'd1;
                     state_q <= accept ? PRESSED : DEBOUNCE;
                  end else begin
                     col_q <= col_q + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (rs == latched_rs) begin
                     cnt_q <= cnt_inc;
                     if (accept) state_q <= PRESSED;
                  end else begin
                     state_q <= SCAN;
                     col_q   <= col_q + 2'd1;
                  end
               end
               PRESSED: begin
                  if (rs_idle) begin
                     cnt_q <= 4'd1;
                     if (DB_LAST == 4'd1) begin
                        state_q    <= SCAN;
                        col_q      <= col_q + 2'd1;
                        key_held_q <= 1'b0;
                     end else begin
                        state_q <= RELEASE;
                     end
                  end
               end
               RELEASE: begin
                  if (rs_idle) begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc == DB_LAST) begin
                        state_q    <= SCAN;
                        col_q      <= col_q + 2'd1;
                        key_held_q <= 1'b0;
                     end
                  end else begin
                     state_q <= PRESSED;
                  end
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign cols      = ~(4'b0001 << col_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driving rows from cols, with a
// transaction-level model of accepted keys and the digit register.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 3;
   localparam int LAT_MAX  = (DB + 1) * SCAN_DIV + 3;

   logic        CLK   = 1'b0;
   logic        reset = 1'b0;
   logic        clr   = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [31:0] digits;

   logic [15:0] key_down  = '0;
   int          checks    = 0;
   int          errors    = 0;
   int          pulse_cnt = 0;
   int          pulses_m  = 0;
   logic [31:0] digits_m  = 32'h0;
   string       keymap_s  = "123A456B789C0FED";

   always #5 CLK = ~CLK;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .clr       (clr),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .digits    (digits)
   );

   // Matrix: a closed switch pulls its row low while its column is driven low.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   always @(negedge CLK) if (key_valid) pulse_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] key_value(input int r, input int c);
      byte ch;
      ch = keymap_s[r*4+c];
      if (ch >= 8'h41) return 4'(ch - 8'h37);
      return 4'(ch - 8'h30);
   endfunction

   function automatic logic [3:0] col_pat(input int c);
      return ~(4'b0001 << c);
   endfunction

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   // Waits for the column to be freshly selected, so tick phase is known.
   task automatic wait_col(input int c);
      logic [3:0] prev;
      bit         ok;
      ok   = 1'b0;
      prev = cols;
      for (int i = 0; i < 64 && !ok; i++) begin
         step();
         if (cols == col_pat(c) && prev != cols) ok = 1'b1;
         prev = cols;
      end
      check("column_reached", 32'(ok), 32'd1);
   endtask

   task automatic wait_pulse(input int p0, output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (pulse_cnt != p0) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic press(input int r, input int c, output int lat);
      int p0;
      wait_col(c);
      p0 = pulse_cnt;
      key_down[r*4+c] = 1'b1;
      wait_pulse(p0, lat);
      pulses_m++;
      digits_m = (digits_m << 4) | 32'(key_value(r, c));
      check("press_latency_ok", 32'(lat >= 1 && lat <= LAT_MAX), 32'd1);
      check("press_key_code", 32'(key_code), 32'(key_value(r, c)));
      check("press_digits", digits, digits_m);
      check("press_key_held", 32'(key_held), 32'd1);
      check("press_pulse_count", 32'(pulse_cnt), 32'(pulses_m));
   endtask

   task automatic release_key(input int r, input int c, output int n_fall);
      key_down[r*4+c] = 1'b0;
      n_fall = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (!key_held) begin
            n_fall = n;
            break;
         end
      end
      check("release_key_held", 32'(key_held), 32'd0);
      check("release_cols_resume", 32'(cols), 32'(col_pat((c + 1) % 4)));
   endtask

   task automatic enter_char(input byte ch);
      int idx, lat, nf;
      idx = 0;
      for (int i = 0; i < 16; i++) if (keymap_s[i] == ch) idx = i;
      press(idx / 4, idx % 4, lat);
      release_key(idx / 4, idx % 4, nf);
   endtask

   initial begin
      int         lat6, lat, nf, p0, k;
      bit         rotated;
      logic [3:0] c0;
      string      seq_s;

      // Reset values
      repeat (3) step();
      check("rst_cols", 32'(cols), 32'h0000000E);
      check("rst_digits", digits, 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_held", 32'(key_held), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);

      // Idle column rotation: one column step every SCAN_DIV clocks
      reset = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         check("idle_rotation", 32'(cols), 32'(col_pat((n / SCAN_DIV) % 4)));
      end

      // Stable press of '6' (row 1, col 2)
      press(1, 2, lat6);
      check("key6_code", 32'(key_code), 32'h6);
      check("key6_digits", digits, 32'h00000006);
      repeat (12) step();
      check("key6_cols_frozen", 32'(cols), 32'hB);
      check("key6_no_repeat", 32'(pulse_cnt), 32'(pulses_m));
      release_key(1, 2, nf);
      check("key6_release_ticks", 32'(nf >= 3 * SCAN_DIV - 1 && nf <= 3 * SCAN_DIV + 2), 32'd1);

      // Bouncing press, then a clean '5'
      wait_col(1);
      p0 = pulse_cnt;
      for (int b = 0; b < 4; b++) begin
         key_down[1*4+1] = (b % 2 == 0);
         repeat (SCAN_DIV) step();
      end
      key_down = '0;
      repeat (2 * SCAN_DIV) step();
      check("bounce_no_pulse", 32'(pulse_cnt), 32'(p0));
      press(1, 1, lat);
      check("bounce_key_code", 32'(key_code), 32'h5);
      release_key(1, 1, nf);

      // Nine entries push the oldest nibble out of the top
      seq_s = "123A456B7";
      for (int i = 0; i < seq_s.len(); i++) enter_char(seq_s[i]);
      check("sequence_digits", digits, 32'h23A456B7);

      // Random keys against the model
      for (int i = 0; i < 6; i++) begin
         k = $urandom_range(0, 15);
         press(k / 4, k % 4, lat);
         release_key(k / 4, k % 4, nf);
      end

      // Two keys in one column are not a key; scanning continues
      p0      = pulse_cnt;
      rotated = 1'b0;
      c0      = cols;
      key_down[0*4+3] = 1'b1;
      key_down[2*4+3] = 1'b1;
      for (int i = 0; i < 48; i++) begin
         step();
         if (cols != c0) rotated = 1'b1;
      end
      check("dual_no_pulse", 32'(pulse_cnt), 32'(p0));
      check("dual_not_held", 32'(key_held), 32'd0);
      check("dual_still_scanning", 32'(rotated), 32'd1);
      key_down = '0;
      repeat (8) step();

      // clr in the same cycle as the shift: clear wins, pulse still fires
      wait_col(2);
      p0 = pulse_cnt;
      key_down[2*4+2] = 1'b1;
      repeat (lat6 - 1) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      pulses_m++;
      digits_m = 32'h0;
      check("clr_key_valid", 32'(key_valid), 32'd1);
      check("clr_digits", digits, 32'h0);
      check("clr_key_code", 32'(key_code), 32'h9);
      check("clr_pulse_count", 32'(pulse_cnt), 32'(p0 + 1));
      step();
      check("clr_digits_hold", digits, 32'h0);
      release_key(2, 2, nf);

      // Plain clr leaves key_code alone
      enter_char("E");
      clr = 1'b1;
      step();
      clr = 1'b0;
      digits_m = 32'h0;
      check("clr_only_digits", digits, 32'h0);
      check("clr_only_key_code", 32'(key_code), 32'hE);

      // Reset while PRESSED; the held key is re-accepted afterwards
      press(1, 0, lat);
      reset = 1'b0;
      #1;
      digits_m = 32'h0;
      check("midrst_cols", 32'(cols), 32'hE);
      check("midrst_digits", digits, 32'h0);
      check("midrst_key_code", 32'(key_code), 32'h0);
      check("midrst_key_held", 32'(key_held), 32'd0);
      check("midrst_key_valid", 32'(key_valid), 32'd0);
      repeat (3) step();
      reset = 1'b1;
      p0 = pulse_cnt;
      wait_pulse(p0, lat);
      pulses_m++;
      digits_m = 32'h4;
      check("repress_seen", 32'(lat > 0), 32'd1);
      check("repress_key_code", 32'(key_code), 32'h4);
      check("repress_digits", digits, digits_m);
      check("repress_key_held", 32'(key_held), 32'd1);
      release_key(1, 0, nf);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
